// File: rtl/sap1_pkg.sv
// -----------------------------------------------------------------------------
// sap1_pkg
// Shared definitions for the SAP-1 program loader.
//   - Default sizes: DEPTH_DEF, ADDR_W_DEF and DATA_W_DEF.
//   - load_state_e: loader FSM state encoding.
// Optional feature macro: LOADER_CHECKSUM_EN adds the CHECK state.
// -----------------------------------------------------------------------------
package sap1_pkg;

  localparam int DEPTH_DEF  = 16;
  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
`ifdef LOADER_CHECKSUM_EN
    ST_CHECK = 3'd3,
`endif
    ST_DONE  = 3'd4
  } load_state_e;

endpackage

// File: rtl/program_loader_if.sv
// -----------------------------------------------------------------------------
// program_loader_if
// Bundles the loader's control, byte-stream, RAM-write and CPU-control signals.
//   master : the side that requests loads and offers bytes (host / bench)
//   slave  : the loader itself
// Byte handshake: a byte moves on a rising Clock edge where rx_valid and
// rx_ready are both high. rx_valid may be raised or dropped freely; the loader
// raises rx_ready only in states that can take a byte, and load_abort on the
// same edge cancels the transfer.
// dbg_state exposes the loader FSM state for observation.
// -----------------------------------------------------------------------------
interface program_loader_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  import sap1_pkg::*;

  logic              load_start;
  logic              load_abort;
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic              rx_ready;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;
  logic              cpu_run;
  logic              cpu_clear;
  logic              load_busy;
  logic [ADDR_W:0]   load_count;
  logic              load_error;
  load_state_e       dbg_state;

  modport master (
    output load_start, load_abort, rx_valid, rx_data,
    input  rx_ready, ram_we, ram_addr, ram_data, cpu_run, cpu_clear,
           load_busy, load_count, load_error, dbg_state
  );

  modport slave (
    input  load_start, load_abort, rx_valid, rx_data,
    output rx_ready, ram_we, ram_addr, ram_data, cpu_run, cpu_clear,
           load_busy, load_count, load_error, dbg_state
  );

endinterface

// File: rtl/program_loader_checksum.sv
// -----------------------------------------------------------------------------
// loader_checksum
// Modulo-2**DATA_W accumulator over the image bytes, with a match test
// against the trailing checksum byte.
// Ports:
//   Clock, Clear    : clock, asynchronous active-high reset
//   i_clear         : zero the sum (start of a new image)
//   i_add, i_data   : add i_data to the sum on this edge
//   i_check_byte    : candidate checksum byte
//   o_match         : sum + i_check_byte == 0 (combinational)
// Only instantiated when LOADER_CHECKSUM_EN is defined.
// -----------------------------------------------------------------------------
module loader_checksum #(
  parameter int DATA_W = 8
) (
  input  logic              Clock,
  input  logic              Clear,
  input  logic              i_clear,
  input  logic              i_add,
  input  logic [DATA_W-1:0] i_data,
  input  logic [DATA_W-1:0] i_check_byte,
  output logic              o_match
);

  logic [DATA_W-1:0] r_sum;
  logic [DATA_W-1:0] w_total;

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear)        r_sum <= '0;
    else if (i_clear) r_sum <= '0;
    else if (i_add)   r_sum <= r_sum + i_data;
  end

  assign w_total = r_sum + i_check_byte;
  assign o_match = (w_total == '0);

endmodule

// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
// Streams DEPTH bytes into the SAP-1 program RAM, holding the CPU off the bus
// while loading, then pulses cpu_clear to restart the CPU.
// Parameters: DEPTH (words per image, = 2**ADDR_W), ADDR_W, DATA_W.
// Ports:
//   Clock : clock, all state changes on posedge
//   Clear : asynchronous active-high reset
//   bus   : program_loader_if.slave (load control, byte stream, RAM write,
//           CPU control, status, dbg_state)
// Optional feature macro: LOADER_CHECKSUM_EN -- after the last data byte a
// checksum byte is taken in CHECK; the image is accepted only if the byte sum
// (including the checksum) is zero mod 2**DATA_W.
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module program_loader
  import sap1_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input logic             Clock,
  input logic             Clear,
  program_loader_if.slave bus
);

  localparam logic [ADDR_W:0]   LP_DEPTH     = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LP_LAST_ADDR = ADDR_W'(DEPTH - 1);

  load_state_e       r_state;
  logic              r_rx_ready;
  logic              r_ram_we;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_data;
  logic              r_cpu_run;
  logic              r_cpu_clear;
  logic              r_load_busy;
  logic [ADDR_W:0]   r_load_count;
  logic              r_load_error;

  logic [ADDR_W:0]   w_count_inc;
  logic              w_hs;

  assign w_count_inc = r_load_count + 1'b1;
  // Raw handshake; load_abort overrides it inside the FSM.
  assign w_hs        = bus.rx_valid && r_rx_ready;

`ifdef LOADER_CHECKSUM_EN
  logic w_sum_clear;
  logic w_sum_add;
  logic w_sum_match;

  assign w_sum_clear = (r_state == ST_IDLE) && bus.load_start;
  assign w_sum_add   = (r_state == ST_LOAD) && w_hs && !bus.load_abort;

  loader_checksum #(.DATA_W(DATA_W)) u_checksum (
    .Clock        (Clock),
    .Clear        (Clear),
    .i_clear      (w_sum_clear),
    .i_add        (w_sum_add),
    .i_data       (bus.rx_data),
    .i_check_byte (bus.rx_data),
    .o_match      (w_sum_match)
  );
`endif

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      r_state      <= ST_IDLE;
      r_rx_ready   <= 1'b0;
      r_ram_we     <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_data   <= '0;
      r_cpu_run    <= 1'b1;
      r_cpu_clear  <= 1'b0;
      r_load_busy  <= 1'b0;
      r_load_count <= '0;
      r_load_error <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.load_start) begin
            r_state      <= ST_LOAD;
            r_ram_addr   <= '0;
            r_load_count <= '0;
            r_load_error <= 1'b0;
            r_cpu_run    <= 1'b0;
            r_rx_ready   <= 1'b1;
            r_load_busy  <= 1'b1;
          end
        end

        ST_LOAD: begin
          if (bus.load_abort) begin
            r_state      <= ST_IDLE;
            r_load_error <= 1'b1;
            r_rx_ready   <= 1'b0;
            r_cpu_run    <= 1'b1;
            r_load_busy  <= 1'b0;
          end else if (w_hs) begin
            r_ram_data <= bus.rx_data;
            r_rx_ready <= 1'b0;
            r_ram_we   <= 1'b1;
            r_state    <= ST_WRITE;
          end
        end

        ST_WRITE: begin
          r_ram_we <= 1'b0;
          if (bus.load_abort) begin
            r_state      <= ST_IDLE;
            r_load_error <= 1'b1;
            r_cpu_run    <= 1'b1;
            r_load_busy  <= 1'b0;
          end else begin
            r_load_count <= w_count_inc;
            // Address parks on the last word instead of wrapping to 0.
            if (r_ram_addr != LP_LAST_ADDR) r_ram_addr <= r_ram_addr + 1'b1;
            if (w_count_inc < LP_DEPTH) begin
              r_state    <= ST_LOAD;
              r_rx_ready <= 1'b1;
            end else begin
`ifdef LOADER_CHECKSUM_EN
              r_state    <= ST_CHECK;
              r_rx_ready <= 1'b1;
`else
              r_state     <= ST_DONE;
              r_cpu_clear <= 1'b1;
`endif
            end
          end
        end

`ifdef LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (bus.load_abort) begin
            r_state      <= ST_IDLE;
            r_load_error <= 1'b1;
            r_rx_ready   <= 1'b0;
            r_cpu_run    <= 1'b1;
            r_load_busy  <= 1'b0;
          end else if (w_hs) begin
            r_rx_ready <= 1'b0;
            if (w_sum_match) begin
              r_state     <= ST_DONE;
              r_cpu_clear <= 1'b1;
            end else begin
              r_state      <= ST_IDLE;
              r_load_error <= 1'b1;
              r_cpu_run    <= 1'b1;
              r_load_busy  <= 1'b0;
            end
          end
        end
`endif

        ST_DONE: begin
          r_cpu_clear <= 1'b0;
          r_state     <= ST_IDLE;
          r_cpu_run   <= 1'b1;
          r_load_busy <= 1'b0;
        end

        default: begin
          r_state     <= ST_IDLE;
          r_rx_ready  <= 1'b0;
          r_ram_we    <= 1'b0;
          r_cpu_clear <= 1'b0;
          r_cpu_run   <= 1'b1;
          r_load_busy <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rx_ready   = r_rx_ready;
  assign bus.ram_we     = r_ram_we;
  assign bus.ram_addr   = r_ram_addr;
  assign bus.ram_data   = r_ram_data;
  assign bus.cpu_run    = r_cpu_run;
  assign bus.cpu_clear  = r_cpu_clear;
  assign bus.load_busy  = r_load_busy;
  assign bus.load_count = r_load_count;
  assign bus.load_error = r_load_error;
  assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_program_loader.sv
`timescale 1ns/1ps
module tb_program_loader;
  import sap1_pkg::*;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int W      = ADDR_W + DATA_W;

  logic Clock;
  logic Clear;

  program_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  program_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .Clock (Clock),
    .Clear (Clear),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial Clock = 1'b0;
  always #10 Clock = ~Clock;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [7:0]   img[DEPTH];
  int  cyc = 0;
  int  last_we = -1000;
  int  wr_cnt = 0;
  int  clr_cnt = 0;
  bit  prev_hs = 0;
  bit  prev_clr = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  // Samples 2ns after each falling edge: inputs are driven exactly on the
  // falling edge, outputs have settled since the previous rising edge.
  always begin
    logic [W-1:0] e;
    @(negedge Clock);
    #2;
    cyc++;
    if (!Clear) begin
      check("run_vs_busy", bus.cpu_run, !bus.load_busy);
      if (bus.ram_we) begin
        check("we_after_hs", prev_hs, 1);
        check("we_gap", (cyc - last_we) >= 2, 1);
        last_we = cyc;
        wr_cnt++;
        if (exp_q.size() == 0) check("we_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("we_addr", bus.ram_addr, e[W-1:DATA_W]);
          check("we_data", bus.ram_data, e[DATA_W-1:0]);
        end
      end
      if (bus.cpu_clear) begin
        check("clr_width", prev_clr, 0);
        check("clr_run_low", bus.cpu_run, 0);
        clr_cnt++;
      end
      if (prev_clr && !bus.cpu_clear) check("run_after_clr", bus.cpu_run, 1);
    end
    prev_clr = bus.cpu_clear && !Clear;
    prev_hs  = bus.rx_valid && bus.rx_ready && !bus.load_abort && !Clear;
  end

  // ---------------- driver tasks ----------------
  task automatic fill_std();
    for (int i = 0; i < DEPTH; i++)
      img[i] = (i == 0) ? 8'h1E : 8'(8'h2F + (i - 1) * 16);
  endtask

  task automatic start_load();
    @(negedge Clock);
    bus.load_start = 1'b1;
    @(negedge Clock);
    bus.load_start = 1'b0;
    check("start_busy", bus.load_busy, 1);
    check("start_run", bus.cpu_run, 0);
    check("start_addr", bus.ram_addr, 0);
    check("start_count", bus.load_count, 0);
    check("start_err", bus.load_error, 0);
  endtask

  // Called on a falling edge; returns on the falling edge after the handshake.
  task automatic send_byte(input logic [7:0] b, input int idle, input bit push,
                           input logic [ADDR_W-1:0] addr);
    bit ok;
    bus.rx_valid = 1'b0;
    repeat (idle) @(negedge Clock);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    ok = 0;
    for (int t = 0; t < 40; t++) begin
      if (bus.rx_ready) begin ok = 1; break; end
      @(negedge Clock);
    end
    check("rdy_timeout", ok, 1);
    if (ok && push) exp_q.push_back({addr, b});
    @(negedge Clock);
    bus.rx_valid = 1'b0;
  endtask

  task automatic run_image(input int max_idle, input int pulse_at, input logic [7:0] ck);
    start_load();
    for (int i = 0; i < DEPTH; i++) begin
      if (i == pulse_at) begin
        bus.load_start = 1'b1;
        repeat (2) @(negedge Clock);
        bus.load_start = 1'b0;
      end
      send_byte(img[i], $urandom_range(0, max_idle), 1, ADDR_W'(i));
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(ck, 0, 0, '0);
`else
    if (ck != 8'h00) check("ck_unused", 0, 0);
`endif
  endtask

  function automatic logic [7:0] neg_sum();
    logic [7:0] s;
    s = 8'h00;
    for (int i = 0; i < DEPTH; i++) s = s + img[i];
    return 8'h00 - s;
  endfunction

  task automatic finish_ok(input int wr0, input int clr0);
    bit found;
    found = 0;
    for (int t = 0; t < 12; t++) begin
      @(negedge Clock); #3;
      if (clr_cnt != clr0) begin found = 1; break; end
    end
    check("clr_seen", found, 1);
    repeat (2) @(negedge Clock);
    #3;
    check("ok_run", bus.cpu_run, 1);
    check("ok_busy", bus.load_busy, 0);
    check("ok_count", bus.load_count, DEPTH);
    check("ok_addr", bus.ram_addr, DEPTH - 1);
    check("ok_err", bus.load_error, 0);
    check("ok_clr_cnt", clr_cnt - clr0, 1);
    check("ok_wr_cnt", wr_cnt - wr0, DEPTH);
    check("ok_q_empty", exp_q.size(), 0);
  endtask

  task automatic finish_err(input int wr0, input int clr0, input int n_wr);
    repeat (4) @(negedge Clock);
    #3;
    check("err_run", bus.cpu_run, 1);
    check("err_busy", bus.load_busy, 0);
    check("err_flag", bus.load_error, 1);
    check("err_no_clr", clr_cnt - clr0, 0);
    check("err_wr_cnt", wr_cnt - wr0, n_wr);
    check("err_q_empty", exp_q.size(), 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    check("watchdog", 0, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    int wr0, clr0;
    Clear = 1'b1;
    bus.load_start = 1'b0;
    bus.load_abort = 1'b0;
    bus.rx_valid   = 1'b0;
    bus.rx_data    = '0;
    repeat (2) @(negedge Clock);
    check("rst_run", bus.cpu_run, 1);
    check("rst_ready", bus.rx_ready, 0);
    check("rst_we", bus.ram_we, 0);
    check("rst_clr", bus.cpu_clear, 0);
    check("rst_busy", bus.load_busy, 0);
    check("rst_err", bus.load_error, 0);
    check("rst_addr", bus.ram_addr, 0);
    check("rst_data", bus.ram_data, 0);
    check("rst_count", bus.load_count, 0);
    Clear = 1'b0;
    repeat (2) @(negedge Clock);
    check("idle_run", bus.cpu_run, 1);

    // Continuous stream.
    fill_std();
    wr0 = wr_cnt; clr0 = clr_cnt;
    run_image(0, -1, neg_sum());
    finish_ok(wr0, clr0);

    // Random gaps in rx_valid.
    wr0 = wr_cnt; clr0 = clr_cnt;
    run_image(3, -1, neg_sum());
    finish_ok(wr0, clr0);

    // load_start pulsed mid-load must not restart the address sequence.
    wr0 = wr_cnt; clr0 = clr_cnt;
    run_image(2, 6, neg_sum());
    finish_ok(wr0, clr0);

    // Abort on the same edge as the 6th handshake.
    wr0 = wr_cnt; clr0 = clr_cnt;
    start_load();
    for (int i = 0; i < 5; i++) send_byte(img[i], 0, 1, ADDR_W'(i));
    bus.rx_data  = img[5];
    bus.rx_valid = 1'b1;
    for (int t = 0; t < 40 && !bus.rx_ready; t++) @(negedge Clock);
    check("abort_rdy", bus.rx_ready, 1);
    bus.load_abort = 1'b1;
    @(negedge Clock);
    bus.load_abort = 1'b0;
    bus.rx_valid   = 1'b0;
    check("abort_count", bus.load_count, 5);
    check("abort_addr", bus.ram_addr, 5);
    check("abort_ready", bus.rx_ready, 0);
    finish_err(wr0, clr0, 5);

    // load_abort in IDLE is ignored.
    @(negedge Clock);
    bus.load_abort = 1'b1;
    @(negedge Clock);
    bus.load_abort = 1'b0;
    check("idle_abort_busy", bus.load_busy, 0);
    check("idle_abort_run", bus.cpu_run, 1);

    // Clear asserted during the WRITE of address 7.
    wr0 = wr_cnt;
    start_load();
    for (int i = 0; i < 8; i++) send_byte(img[i], 0, 1, ADDR_W'(i));
    check("mid_we", bus.ram_we, 1);
    #5;
    Clear = 1'b1;
    #1;
    check("clr_run", bus.cpu_run, 1);
    check("clr_ready", bus.rx_ready, 0);
    check("clr_we", bus.ram_we, 0);
    check("clr_cpu_clear", bus.cpu_clear, 0);
    check("clr_busy", bus.load_busy, 0);
    check("clr_err", bus.load_error, 0);
    check("clr_addr", bus.ram_addr, 0);
    check("clr_data", bus.ram_data, 0);
    check("clr_count", bus.load_count, 0);
    @(negedge Clock);
    Clear = 1'b0;
    repeat (4) @(negedge Clock);
    #3;
    check("clr_wr_cnt", wr_cnt - wr0, 8);
    check("clr_q_empty", exp_q.size(), 0);
    check("clr_idle_busy", bus.load_busy, 0);

`ifdef LOADER_CHECKSUM_EN
    // 16 x 0x01 with a matching checksum, then a wrong one.
    for (int i = 0; i < DEPTH; i++) img[i] = 8'h01;
    wr0 = wr_cnt; clr0 = clr_cnt;
    run_image(1, -1, 8'hF0);
    finish_ok(wr0, clr0);
    wr0 = wr_cnt; clr0 = clr_cnt;
    run_image(1, -1, 8'hF1);
    finish_err(wr0, clr0, DEPTH);
`endif

    repeat (3) @(negedge Clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
